// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect and the
// decode-facing output register, bundled so the controller has one port.
interface fetch_controller_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, keeps one memory request in flight,
// and hands fetched words to decode through a valid/ready output register.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        req_valid;
    logic [31:0] redirect_target;

    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        req_valid  = 1'b0;

        // Decode consumption; a refill or flush below overrides it.
        if (if_valid_q && bus.id_ready) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            FETCH: begin
                // Only issue when the output register is free by the time the response lands.
                req_valid = !bus.redirect_valid && (!if_valid_q || bus.id_ready);
                if (bus.redirect_valid) begin
                    pc_d       = redirect_target;
                    if_valid_d = 1'b0;
                end else if (req_valid && bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d       = redirect_target;
                    if_valid_d = 1'b0;
                    state_d    = bus.imem_rsp_valid ? FETCH : DISCARD;
                end else if (bus.imem_rsp_valid) begin
                    if_valid_d = 1'b1;
                    if_instr_d = bus.imem_rsp_data;
                    if_pc_d    = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                if (bus.redirect_valid) begin
                    pc_d       = redirect_target;
                    if_valid_d = 1'b0;
                end
                if (bus.imem_rsp_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.if_pc          = if_pc_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: transaction-level model plus per-cycle compare,
// directed scenarios with literal expectations, and a latency-programmable memory.
module tb_fetch_controller;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus driven into both DUT copies.
    logic        tb_req_ready = 1'b1;
    logic        tb_redirect = 1'b0;
    logic [31:0] tb_redirect_pc = 32'h0;
    logic        tb_id_ready = 1'b1;
    logic        tb_rsp_valid;
    logic [31:0] tb_rsp_data;

    fetch_controller_if if0 ();
    fetch_controller_if if1 ();

    assign if0.imem_req_ready = tb_req_ready;
    assign if0.imem_rsp_valid = tb_rsp_valid;
    assign if0.imem_rsp_data  = tb_rsp_data;
    assign if0.redirect_valid = tb_redirect;
    assign if0.redirect_pc    = tb_redirect_pc;
    assign if0.id_ready       = tb_id_ready;
    assign if1.imem_req_ready = tb_req_ready;
    assign if1.imem_rsp_valid = tb_rsp_valid;
    assign if1.imem_rsp_data  = tb_rsp_data;
    assign if1.redirect_valid = tb_redirect;
    assign if1.redirect_pc    = tb_redirect_pc;
    assign if1.id_ready       = tb_id_ready;

    fetch_controller #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.master)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.master)
    );

    // sel picks which copy is under check; the model tracks that one.
    bit          sel = 1'b0;
    logic        act_req, act_vld;
    logic [31:0] act_addr, act_instr, act_pc;
    assign act_req   = sel ? if1.imem_req_valid : if0.imem_req_valid;
    assign act_addr  = sel ? if1.imem_addr      : if0.imem_addr;
    assign act_vld   = sel ? if1.if_valid       : if0.if_valid;
    assign act_instr = sel ? if1.if_instr       : if0.if_instr;
    assign act_pc    = sel ? if1.if_pc          : if0.if_pc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0013 + (a << 8);
    endfunction

    // Behavioural model: fetch has started, a request is in flight, that request is stale.
    logic [31:0] m_reset_pc = 32'h0;
    bit          m_started, m_outstanding, m_stale, m_vld;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        exp_req, fire;
    int          mem_lat = 1;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'h0;

    assign exp_req = m_started && !m_outstanding && !tb_redirect && (!m_vld || tb_id_ready);
    assign fire    = exp_req && tb_req_ready;

    // Memory: answers mem_lat cycles after acceptance; it does not forget across reset.
    assign tb_rsp_valid = (rsp_cnt == 1);
    assign tb_rsp_data  = mem_word(rsp_addr);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_started     <= 1'b0;
            m_outstanding <= 1'b0;
            m_stale       <= 1'b0;
            m_vld         <= 1'b0;
            m_pc          <= m_reset_pc;
            m_instr       <= NOP;
            m_ipc         <= m_reset_pc;
        end else begin
            if (fire) begin
                rsp_cnt  <= mem_lat;
                rsp_addr <= m_pc;
            end else if (rsp_cnt > 0) begin
                rsp_cnt <= rsp_cnt - 1;
            end

            if (!m_started) begin
                m_started <= 1'b1;
                if (tb_redirect) m_pc <= {tb_redirect_pc[31:2], 2'b00};
            end else if (tb_redirect) begin
                m_pc  <= {tb_redirect_pc[31:2], 2'b00};
                m_vld <= 1'b0;
                if (m_outstanding) begin
                    if (tb_rsp_valid) begin
                        m_outstanding <= 1'b0;
                        m_stale       <= 1'b0;
                    end else begin
                        m_stale <= 1'b1;
                    end
                end
            end else begin
                if (m_vld && tb_id_ready) m_vld <= 1'b0;
                if (m_outstanding && tb_rsp_valid) begin
                    m_outstanding <= 1'b0;
                    m_stale       <= 1'b0;
                    if (!m_stale) begin
                        m_vld   <= 1'b1;
                        m_instr <= mem_word(m_pc);
                        m_ipc   <= m_pc;
                        m_pc    <= m_pc + 32'd4;
                    end
                end else if (fire) begin
                    m_outstanding <= 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle after inputs have settled.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("req_valid", {31'b0, act_req}, {31'b0, exp_req});
            check("imem_addr", act_addr, m_pc);
            check("if_valid", {31'b0, act_vld}, {31'b0, m_vld});
            check("if_instr", act_instr, m_instr);
            check("if_pc", act_pc, m_ipc);
        end
    end

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] rpc, input bit s);
        @(negedge clk);
        m_reset_pc   = rpc;
        sel          = s;
        reset        = 1'b1;
        tb_redirect  = 1'b0;
        tb_req_ready = 1'b1;
        tb_id_ready  = 1'b1;
        mem_lat      = 1;
        go(2);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        go(2);
        chk_en = 1'b1;
        #3;
        check("rst req_valid", {31'b0, act_req}, 32'd0);
        check("rst if_instr", act_instr, NOP);
        check("rst if_pc", act_pc, 32'h0);

        // Zero-wait memory: requests at 0, 4, 8; first if_valid on cycle 3.
        go(1); reset = 1'b0;
        #3 check("A c0 req", {31'b0, act_req}, 32'd0);
        go(1); #3 check("A c1 req", {31'b0, act_req}, 32'd1);
        check("A c1 addr", act_addr, 32'h0);
        go(1); #3 check("A c2 vld", {31'b0, act_vld}, 32'd0);
        go(1); #3 check("A c3 vld", {31'b0, act_vld}, 32'd1);
        check("A c3 pc", act_pc, 32'h0);
        check("A c3 instr", act_instr, 32'h1000_0013);
        check("A c3 addr", act_addr, 32'h4);
        go(2); #3 check("A c5 pc", act_pc, 32'h4);
        check("A c5 instr", act_instr, 32'h1000_0413);
        check("A c5 addr", act_addr, 32'h8);
        go(2); #3 check("A c7 pc", act_pc, 32'h8);

        // Request back-pressure for three cycles, then a decode stall.
        do_reset(32'h0, 1'b0);
        tb_req_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            go(1); #3;
            check("B hold req", {31'b0, act_req}, 32'd1);
            check("B hold addr", act_addr, 32'h0);
        end
        go(1); tb_req_ready = 1'b1;
        go(2); tb_id_ready = 1'b0;
        #3 check("C c6 vld", {31'b0, act_vld}, 32'd1);
        check("C c6 req", {31'b0, act_req}, 32'd0);
        go(2); #3 check("C c8 req", {31'b0, act_req}, 32'd0);
        check("C c8 instr", act_instr, 32'h1000_0013);
        check("C c8 pc", act_pc, 32'h0);
        go(1); tb_id_ready = 1'b1;
        #3 check("C c9 req", {31'b0, act_req}, 32'd1);
        check("C c9 addr", act_addr, 32'h4);
        go(2); #3 check("C c11 pc", act_pc, 32'h4);

        // Redirect in WAIT to 0x100; stale response lands two cycles later.
        do_reset(32'h0, 1'b0);
        mem_lat = 3;
        go(2); tb_redirect = 1'b1; tb_redirect_pc = 32'h100;
        #3 check("D c2 req", {31'b0, act_req}, 32'd0);
        go(1); tb_redirect = 1'b0;
        go(1); #3 check("D c4 rsp", {31'b0, tb_rsp_valid}, 32'd1);
        check("D c4 vld", {31'b0, act_vld}, 32'd0);
        go(1); #3 check("D c5 vld", {31'b0, act_vld}, 32'd0);
        check("D c5 req", {31'b0, act_req}, 32'd1);
        check("D c5 addr", act_addr, 32'h100);
        go(4); #3 check("D c9 pc", act_pc, 32'h100);
        check("D c9 instr", act_instr, 32'h1001_0013);

        // Redirect coincident with the response, unaligned target 0x203.
        do_reset(32'h0, 1'b0);
        go(2); tb_redirect = 1'b1; tb_redirect_pc = 32'h203;
        go(1); tb_redirect = 1'b0;
        #3 check("E c3 vld", {31'b0, act_vld}, 32'd0);
        check("E c3 addr", act_addr, 32'h200);
        go(2); #3 check("E c5 pc", act_pc, 32'h200);
        check("E c5 instr", act_instr, 32'h1002_0013);

        // PC wrap from 0xFFFF_FFFC, then async reset in the middle of WAIT.
        do_reset(32'hFFFF_FFFC, 1'b1);
        #3 check("F c0 addr", act_addr, 32'hFFFF_FFFC);
        go(3); #3 check("F c3 pc", act_pc, 32'hFFFF_FFFC);
        check("F c3 instr", act_instr, 32'h0FFF_FC13);
        check("F c3 addr", act_addr, 32'h0);
        go(1); #3 reset = 1'b1;
        #1 check("F rst req", {31'b0, act_req}, 32'd0);
        check("F rst addr", act_addr, 32'hFFFF_FFFC);
        check("F rst vld", {31'b0, act_vld}, 32'd0);
        check("F rst instr", act_instr, NOP);
        check("F rst pc", act_pc, 32'hFFFF_FFFC);
        go(1); reset = 1'b0;
        go(3); #3 check("F post vld", {31'b0, act_vld}, 32'd1);
        check("F post pc", act_pc, 32'hFFFF_FFFC);
        go(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
